// File: rtl/xor_serial_ctrl.sv
// xor_serial_ctrl
//   Bit-serial sequencer that time-shares one external 1-bit XOR gate to
//   compute the XOR of two WIDTH-bit operands, LSB first.
//
//   Operands are captured on the edge that accepts start.
//   One bit pair is then presented per cycle on gate_a/gate_b.
//   The gate's answer (gate_y) is shifted into a result register.
//   After WIDTH cycles the result and its parity are published, and done
//   pulses for one cycle.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   begin an operation (sampled only in IDLE)
//   a_in    operand A, captured on the accepting edge
//   b_in    operand B, captured on the accepting edge
//   gate_a  bit to XOR gate input a (0 outside SHIFT)
//   gate_b  bit to XOR gate input b (0 outside SHIFT)
//   gate_y  XOR gate output, combinational from gate_a/gate_b
//   busy    high while bits are being shifted
//   done    one-cycle completion pulse
//   result  last completed XOR result, held between operations
//   parity  XOR-reduction of result, updated with result
module xor_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             parity
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             parity_q, parity_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Shift value including this cycle's gate answer.
  // On the last bit, this is the value that gets published.
  logic [WIDTH-1:0] res_next;
  assign res_next = {gate_y, res_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    parity_d = parity_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next;
        // Counter holds at LAST on exit so it never wraps.
        if (cnt_q == LAST) begin
          result_d = res_next;
          parity_d = ^res_next;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      parity_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      parity_q <= parity_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign gate_a = (state_q == SHIFT) & a_sh_q[0];
  assign gate_b = (state_q == SHIFT) & b_sh_q[0];
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign parity = parity_q;

endmodule

// File: tb/tb_xor_serial_ctrl.sv
// Testbench for xor_serial_ctrl (WIDTH=8).
// The XOR gate itself is modelled here as gate_y = gate_a ^ gate_b.
module tb_xor_serial_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         gate_a, gate_b, gate_y;
  logic         busy, done;
  logic [W-1:0] result;
  logic         parity;

  always #5 clk = ~clk;

  assign gate_y = gate_a ^ gate_b;

  xor_serial_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .gate_a (gate_a),
    .gate_b (gate_b),
    .gate_y (gate_y),
    .busy   (busy),
    .done   (done),
    .result (result),
    .parity (parity)
  );

  int checks = 0;
  int errors = 0;

  logic [W:0]   res_q[$];   // {parity, result} per expected completion
  logic [1:0]   gate_q[$];  // {gate_a, gate_b} per expected shift cycle
  logic [W-1:0] held_res = '0;
  logic         held_par = 1'b0;
  bit           gate_chk = 1'b1;
  bit           b2b = 1'b0;
  int           cyc = 0;
  int           last_done = -1;
  int           busy_low = 0;
  int           done_cnt = 0;
  logic         prev_busy = 1'b0;
  logic         prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ep);
    res_q.push_back({ep, er});
    for (int i = 0; i < int'(W); i++) gate_q.push_back({a[i], b[i]});
  endtask

  // Scoreboard monitor: samples on the falling edge
  always @(negedge clk) begin
    logic [1:0] g;
    logic [W:0] e;
    cyc++;
    if (!rst) begin
      if (busy) begin
        chk("hold_result", {23'd0, parity, result}, {23'd0, held_par, held_res});
        if (gate_chk) begin
          if (gate_q.size() == 0) fail_now("unexpected_busy");
          else begin
            g = gate_q.pop_front();
            chk("gate_pair", {30'd0, gate_a, gate_b}, {30'd0, g});
          end
        end
      end else begin
        chk("gate_idle", {30'd0, gate_a, gate_b}, 32'd0);
      end
      if (done) begin
        done_cnt++;
        chk("done_width", {31'd0, prev_done}, 32'd0);
        chk("done_busy_excl", {31'd0, busy}, 32'd0);
        if (res_q.size() == 0) fail_now("unexpected_done");
        else begin
          e = res_q.pop_front();
          chk("result", {24'd0, result}, {24'd0, e[W-1:0]});
          chk("parity", {31'd0, parity}, {31'd0, e[W]});
          held_res = e[W-1:0];
          held_par = e[W];
        end
        if (b2b && last_done >= 0) chk("done_interval", cyc - last_done, 32'd10);
        last_done = cyc;
      end
      if (busy && !prev_busy && b2b && last_done >= 0) chk("busy_gap", busy_low, 32'd2);
      busy_low = busy ? 0 : busy_low + 1;
    end
    prev_busy = busy;
    prev_done = done;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!busy && !done) return;
      step();
    end
    fail_now("timeout_idle");
  endtask

  task automatic wait_done();
    for (int i = 0; i < int'(W) + 6; i++) begin
      if (done) return;
      step();
    end
    fail_now("timeout_done");
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ep);
    wait_idle();
    push_op(a, b, er, ep);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    step();
  endtask

  initial begin
    int base;
    int n;
    bit got;
    // Reset with start asserted and random operands
    rst   = 1'b1;
    start = 1'b1;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    for (int i = 0; i < 4; i++) begin
      step();
      a_in = W'($urandom);
      b_in = W'($urandom);
      chk("reset_outputs", {22'd0, result, parity, busy, done, gate_a, gate_b}, 32'd0);
    end
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_after_reset", {30'd0, busy, done}, 32'd0);
    end

    // Basic operation
    run_op(8'hA5, 8'h3C, 8'h99, 1'b0);
    // Odd parity, then result held during the next busy window
    run_op(8'h01, 8'h00, 8'h01, 1'b1);
    run_op(8'hFF, 8'h00, 8'hFF, 1'b0);

    // start and operand changes mid-SHIFT are ignored
    wait_idle();
    base = done_cnt;
    push_op(8'h0F, 8'hF0, 8'hFF, 1'b0);
    a_in  = 8'h0F;
    b_in  = 8'hF0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    wait_done();
    for (int i = 0; i < 12; i++) step();
    chk("single_done", done_cnt - base, 32'd1);
    chk("no_second_op", {31'd0, busy}, 32'd0);

    // Back-to-back with start held high
    wait_idle();
    last_done = -1;
    b2b = 1'b1;
    for (int i = 0; i < 3; i++) push_op(8'h55, 8'hAA, 8'hFF, 1'b0);
    a_in  = 8'h55;
    b_in  = 8'hAA;
    start = 1'b1;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) begin
        n++;
        if (n == 3) begin
          start = 1'b0;
          got = 1'b1;
          break;
        end
      end
    end
    if (!got) begin
      start = 1'b0;
      fail_now("timeout_b2b");
    end
    step();
    step();
    b2b = 1'b0;

    // Reset during the 4th SHIFT cycle
    wait_idle();
    base = done_cnt;
    gate_chk = 1'b0;
    a_in  = 8'h12;
    b_in  = 8'h34;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {22'd0, result, parity, busy, done, gate_a, gate_b}, 32'd0);
    held_res = '0;
    held_par = 1'b0;
    step();
    step();
    chk("abort_outputs_held", {22'd0, result, parity, busy, done, gate_a, gate_b}, 32'd0);
    chk("abort_no_done", done_cnt - base, 32'd0);
    // Release reset with start on the very first edge
    gate_chk = 1'b1;
    push_op(8'h12, 8'h34, 8'h26, 1'b1);
    rst   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("accept_after_reset", {31'd0, busy}, 32'd1);
    wait_done();
    for (int i = 0; i < 4; i++) step();

    chk("res_queue_empty", res_q.size(), 32'd0);
    chk("gate_queue_empty", gate_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
